aemb2_xsl_fifo: RTL and testbench

AEMB2_XSL_FIFO -- requirements
Module: aemb2_xsl_fifo

---
 rtl/aemb2_xsl_fifo_pkg.sv | 14 +
 rtl/aemb2_xsl_fifo_if.sv | 24 ++
 rtl/aemb2_xsl_sfifo.sv | 49 ++++
 rtl/aemb2_xsl_fifo.sv | 101 ++++++++++
 tb/tb_aemb2_xsl_fifo.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aemb2_xsl_fifo_pkg.sv
// rtl/aemb2_xsl_fifo_pkg.sv - shared XSL entry layout and channel-count derivation
package aemb2_xsl_fifo_pkg;

   localparam int XSL_W   = 33;
   localparam int TAG_BIT = 32;

   typedef logic [XSL_W-1:0] xsl_entry_t;

   // One channel per XSEL address value below the top bit.
   function automatic int xsl_ch(input int aemb_xwb);
      return 1 << (aemb_xwb - 2);
   endfunction

endpackage

// File: rtl/aemb2_xsl_fifo_if.sv
// rtl/aemb2_xsl_fifo_if.sv - core-side XSL bus bundle with master/slave views
interface aemb2_xsl_fifo_if #(
   parameter int AEMB_XWB = 3
);
   logic [AEMB_XWB-3:0] xwb_adr_i;
   logic [31:0]         xwb_dat_i;
   logic [3:0]          xwb_sel_i;
   logic                xwb_tag_i;
   logic                xwb_stb_i;
   logic                xwb_cyc_i;
   logic                xwb_wre_i;
   logic [31:0]         xwb_dat_o;
   logic                xwb_ack_o;

   modport master (
      output xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_tag_i, xwb_stb_i, xwb_cyc_i, xwb_wre_i,
      input  xwb_dat_o, xwb_ack_o
   );

   modport slave (
      input  xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_tag_i, xwb_stb_i, xwb_cyc_i, xwb_wre_i,
      output xwb_dat_o, xwb_ack_o
   );
endinterface

// File: rtl/aemb2_xsl_sfifo.sv
// rtl/aemb2_xsl_sfifo.sv - synchronous first-word-fall-through FIFO of XSL entries
module aemb2_xsl_sfifo
   import aemb2_xsl_fifo_pkg::*;
#(
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  xsl_entry_t push_dat,
   input  logic       pop,
   output xsl_entry_t pop_dat,
   output logic       full,
   output logic       empty
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic [FIFO_AW:0] wr_d, wr_q, rd_d, rd_q;
   logic             push_ok, pop_ok;
   xsl_entry_t       mem_q [DEPTH];

   // Status comes from the pre-edge pointers, so a full FIFO refuses a push
   // even when a pop happens on the same edge (and likewise for empty/pop).
   always_comb begin
      full    = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
      empty   = (wr_q == rd_q);
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      wr_d    = wr_q + {{FIFO_AW{1'b0}}, push_ok};
      rd_d    = rd_q + {{FIFO_AW{1'b0}}, pop_ok};
      pop_dat = mem_q[rd_q[FIFO_AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[FIFO_AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/aemb2_xsl_fifo.sv
// rtl/aemb2_xsl_fifo.sv - XSL core-to-accelerator bridge with per-channel PUT/GET FIFOs
module aemb2_xsl_fifo
   import aemb2_xsl_fifo_pkg::*;
#(
   parameter  int AEMB_XWB = 3,
   parameter  int FIFO_AW  = 2,
   localparam int CH       = xsl_ch(AEMB_XWB)
) (
   input  logic              gclk,
   input  logic              grst,
   aemb2_xsl_fifo_if.slave   xwb,
   output logic [CH*32-1:0]  put_dat_o,
   output logic [CH-1:0]     put_tag_o,
   output logic [CH-1:0]     put_vld_o,
   input  logic [CH-1:0]     put_rdy_i,
   input  logic [CH*32-1:0]  get_dat_i,
   input  logic [CH-1:0]     get_tag_i,
   input  logic [CH-1:0]     get_vld_i,
   output logic [CH-1:0]     get_rdy_o,
   output logic              tag_err_o
);
   logic        req, accept;
   logic        ack_d, ack_q;
   logic        tag_err_d, tag_err_q;
   logic [31:0] dat_d, dat_q;

   logic [CH-1:0] put_push, put_pop, put_full, put_empty;
   logic [CH-1:0] get_push, get_pop, get_full, get_empty;
   logic [CH-1:0][XSL_W-1:0] put_head, get_head;

   logic unused_sel;
   assign unused_sel = ^xwb.xwb_sel_i;

   // Ack is registered and self-masking, so a held strobe is acked at most every other cycle.
   always_comb begin
      req       = xwb.xwb_stb_i & xwb.xwb_cyc_i;
      accept    = xwb.xwb_wre_i ? ~put_full[xwb.xwb_adr_i] : ~get_empty[xwb.xwb_adr_i];
      ack_d     = req & ~ack_q & accept;
      put_push  = '0;
      get_pop   = '0;
      dat_d     = dat_q;
      tag_err_d = 1'b0;
      if (ack_d) begin
         if (xwb.xwb_wre_i) begin
            put_push[xwb.xwb_adr_i] = 1'b1;
         end else begin
            get_pop[xwb.xwb_adr_i] = 1'b1;
            dat_d     = get_head[xwb.xwb_adr_i][31:0];
            tag_err_d = get_head[xwb.xwb_adr_i][TAG_BIT] != xwb.xwb_tag_i;
         end
      end
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         ack_q     <= 1'b0;
         dat_q     <= 32'h0;
         tag_err_q <= 1'b0;
      end else begin
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         tag_err_q <= tag_err_d;
      end
   end

   assign xwb.xwb_ack_o = ack_q;
   assign xwb.xwb_dat_o = dat_q;
   assign tag_err_o     = tag_err_q;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      assign put_pop[c]          = ~put_empty[c] & put_rdy_i[c];
      assign get_push[c]         = get_vld_i[c] & ~get_full[c];
      assign put_vld_o[c]        = ~put_empty[c];
      assign get_rdy_o[c]        = ~get_full[c];
      assign put_dat_o[32*c+:32] = put_head[c][31:0];
      assign put_tag_o[c]        = put_head[c][TAG_BIT];

      aemb2_xsl_sfifo #(.FIFO_AW(FIFO_AW)) u_put (
         .clk      (gclk),
         .rst_n    (grst),
         .push     (put_push[c]),
         .push_dat ({xwb.xwb_tag_i, xwb.xwb_dat_i}),
         .pop      (put_pop[c]),
         .pop_dat  (put_head[c]),
         .full     (put_full[c]),
         .empty    (put_empty[c])
      );

      aemb2_xsl_sfifo #(.FIFO_AW(FIFO_AW)) u_get (
         .clk      (gclk),
         .rst_n    (grst),
         .push     (get_push[c]),
         .push_dat ({get_tag_i[c], get_dat_i[32*c+:32]}),
         .pop      (get_pop[c]),
         .pop_dat  (get_head[c]),
         .full     (get_full[c]),
         .empty    (get_empty[c])
      );
   end

endmodule

// File: tb/tb_aemb2_xsl_fifo.sv
// tb/tb_aemb2_xsl_fifo.sv - scoreboard bench for aemb2_xsl_fifo
module tb_aemb2_xsl_fifo;
   import aemb2_xsl_fifo_pkg::*;

   localparam int AEMB_XWB = 3;
   localparam int FIFO_AW  = 2;
   localparam int CH       = 2;
   localparam int DEPTH    = 4;

   logic gclk = 1'b0;
   logic grst = 1'b0;

   aemb2_xsl_fifo_if #(.AEMB_XWB(AEMB_XWB)) xwb_if ();

   logic [CH*32-1:0] put_dat_o, get_dat_i;
   logic [CH-1:0]    put_tag_o, put_vld_o, put_rdy_i;
   logic [CH-1:0]    get_tag_i, get_vld_i, get_rdy_o;
   logic             tag_err_o;

   aemb2_xsl_fifo #(.AEMB_XWB(AEMB_XWB), .FIFO_AW(FIFO_AW)) dut (
      .gclk      (gclk),
      .grst      (grst),
      .xwb       (xwb_if),
      .put_dat_o (put_dat_o),
      .put_tag_o (put_tag_o),
      .put_vld_o (put_vld_o),
      .put_rdy_i (put_rdy_i),
      .get_dat_i (get_dat_i),
      .get_tag_i (get_tag_i),
      .get_vld_i (get_vld_i),
      .get_rdy_o (get_rdy_o),
      .tag_err_o (tag_err_o)
   );

   always #5 gclk = ~gclk;

   typedef struct {
      bit          wre;
      int          adr;
      bit          tag;
      logic [31:0] dat;
   } pend_t;

   pend_t             pend_q[$];
   logic [XSL_W-1:0]  put_q[CH][$];
   logic [XSL_W-1:0]  get_q[CH][$];

   int          checks = 0;
   int          errors = 0;
   bit          mdl_rst = 1'b1;
   bit          exp_ack = 1'b0;
   bit          exp_err = 1'b0;
   logic [31:0] last_dat = 32'h0;

   bit               acc_rand = 1'b0;
   logic [CH-1:0]    dir_put_rdy = '0;
   logic [CH-1:0]    dir_get_vld = '0;
   logic [CH-1:0]    dir_get_tag = '0;
   logic [CH*32-1:0] dir_get_dat = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Accelerator-side driver: random traffic or directed values, updated just after each edge.
   initial begin
      put_rdy_i = '0;
      get_vld_i = '0;
      get_tag_i = '0;
      get_dat_i = '0;
      forever begin
         @(posedge gclk);
         #2;
         if (acc_rand) begin
            put_rdy_i = CH'($urandom);
            get_vld_i = CH'($urandom);
            get_tag_i = CH'($urandom);
            get_dat_i = {$urandom, $urandom};
         end else begin
            put_rdy_i = dir_put_rdy;
            get_vld_i = dir_get_vld;
            get_tag_i = dir_get_tag;
            get_dat_i = dir_get_dat;
         end
      end
   end

   // Reference model: per-channel queues, advanced once per cycle between edges.
   always @(negedge gclk) begin : monitor
      pend_t            p;
      logic [XSL_W-1:0] e;
      bit               req, acc;
      int               a;
      if (mdl_rst) begin
         for (int c = 0; c < CH; c++) begin
            put_q[c].delete();
            get_q[c].delete();
         end
         pend_q.delete();
         exp_ack  = 1'b0;
         exp_err  = 1'b0;
         last_dat = 32'h0;
      end else begin
         chk("ack", xwb_if.xwb_ack_o, exp_ack);
         exp_err = 1'b0;
         if (exp_ack) begin
            if (pend_q.size() == 0) begin
               chk("pending_request", 0, 1);
            end else begin
               p = pend_q.pop_front();
               if (p.wre) begin
                  put_q[p.adr].push_back({p.tag, p.dat});
               end else begin
                  e = get_q[p.adr].pop_front();
                  last_dat = e[31:0];
                  exp_err  = e[TAG_BIT] != p.tag;
               end
            end
         end
         chk("dat_o", xwb_if.xwb_dat_o, last_dat);
         chk("tag_err", tag_err_o, exp_err);
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("put_vld%0d", c), put_vld_o[c], put_q[c].size() > 0);
            chk($sformatf("get_rdy%0d", c), get_rdy_o[c], get_q[c].size() < DEPTH);
            if (put_q[c].size() > 0) begin
               chk($sformatf("put_dat%0d", c), put_dat_o[32*c+:32], put_q[c][0][31:0]);
               chk($sformatf("put_tag%0d", c), put_tag_o[c], put_q[c][0][TAG_BIT]);
            end
         end
         req = xwb_if.xwb_stb_i & xwb_if.xwb_cyc_i;
         a   = int'(xwb_if.xwb_adr_i);
         acc = xwb_if.xwb_wre_i ? (put_q[a].size() < DEPTH) : (get_q[a].size() > 0);
         exp_ack = req && !exp_ack && acc;
         for (int c = 0; c < CH; c++) begin
            if (put_q[c].size() > 0 && put_rdy_i[c]) void'(put_q[c].pop_front());
            if (get_vld_i[c] && get_q[c].size() < DEPTH)
               get_q[c].push_back({get_tag_i[c], get_dat_i[32*c+:32]});
         end
      end
   end

   task automatic xact(input bit w, input int a, input bit t, input logic [31:0] d,
                       input int n, input int budget, output int got, output int cyc);
      pend_t p;
      p.wre = w; p.adr = a; p.tag = t; p.dat = d;
      for (int i = 0; i < n; i++) pend_q.push_back(p);
      @(posedge gclk);
      #1;
      xwb_if.xwb_wre_i = w;
      xwb_if.xwb_adr_i = (AEMB_XWB-2)'(a);
      xwb_if.xwb_tag_i = t;
      xwb_if.xwb_dat_i = d;
      xwb_if.xwb_stb_i = 1'b1;
      xwb_if.xwb_cyc_i = 1'b1;
      got = 0;
      cyc = 0;
      while (got < n && cyc < budget) begin
         @(posedge gclk);
         #1;
         cyc++;
         if (xwb_if.xwb_ack_o) got++;
      end
      xwb_if.xwb_stb_i = 1'b0;
      xwb_if.xwb_cyc_i = 1'b0;
      xwb_if.xwb_dat_i = $urandom;
      for (int i = got; i < n; i++) void'(pend_q.pop_back());
   endtask

   task automatic rst_assert();
      @(posedge gclk);
      #3;
      mdl_rst = 1'b1;
      grst    = 1'b0;
      #1;
      chk("rst_ack", xwb_if.xwb_ack_o, 0);
      chk("rst_dat", xwb_if.xwb_dat_o, 0);
      chk("rst_tag_err", tag_err_o, 0);
      chk("rst_put_vld", put_vld_o, 0);
      chk("rst_get_rdy", get_rdy_o, {CH{1'b1}});
   endtask

   task automatic rst_release();
      @(posedge gclk);
      #1;
      grst    = 1'b1;
      mdl_rst = 1'b0;
   endtask

   initial begin : main
      int got, cyc, acks;
      xwb_if.xwb_adr_i = '0;
      xwb_if.xwb_dat_i = '0;
      xwb_if.xwb_sel_i = 4'hF;
      xwb_if.xwb_tag_i = 1'b0;
      xwb_if.xwb_stb_i = 1'b0;
      xwb_if.xwb_cyc_i = 1'b0;
      xwb_if.xwb_wre_i = 1'b0;
      rst_assert();
      rst_release();

      // Single PUT with an always-ready accelerator.
      dir_put_rdy = 2'b11;
      xact(1, 0, 1, 32'hDEADBEEF, 1, 10, got, cyc);
      chk("put_got", got, 1);
      chk("put_latency", cyc, 1);
      @(negedge gclk);
      chk("put_vld_after_ack", put_vld_o[0], 1);
      chk("put_dat_after_ack", put_dat_o[31:0], 32'hDEADBEEF);
      chk("put_tag_after_ack", put_tag_o[0], 1);

      // GET on ch1 blocks until the accelerator supplies a word.
      dir_put_rdy = 2'b00;
      fork
         xact(0, 1, 0, 32'h0, 1, 30, got, cyc);
         begin
            repeat (10) @(posedge gclk);
            #1;
            dir_get_vld = 2'b10;
            dir_get_tag = 2'b00;
            dir_get_dat = {32'h12345678, 32'h0};
            @(posedge gclk);
            #1;
            dir_get_vld = 2'b00;
         end
      join
      chk("get_blocked_got", got, 1);
      chk("get_blocked_latency", cyc, 11);
      @(negedge gclk);
      chk("get_blocked_dat", xwb_if.xwb_dat_o, 32'h12345678);

      // Fill ch0 PUT FIFO, fifth is refused until one entry drains.
      for (int i = 0; i < DEPTH; i++) begin
         xact(1, 0, 0, 32'h100 + i, 1, 10, got, cyc);
         chk($sformatf("fill_got%0d", i), got, 1);
      end
      xact(1, 0, 1, 32'h105, 1, 6, got, cyc);
      chk("full_blocked", got, 0);
      fork
         xact(1, 0, 1, 32'h105, 1, 20, got, cyc);
         begin
            repeat (3) @(posedge gclk);
            #1;
            dir_put_rdy = 2'b01;
            @(posedge gclk);
            #1;
            dir_put_rdy = 2'b00;
         end
      join
      chk("full_release_got", got, 1);
      chk("full_release_latency", cyc, 4);
      dir_put_rdy = 2'b11;
      repeat (8) @(posedge gclk);

      // Tag mismatch on GET.
      #1;
      dir_get_vld = 2'b01;
      dir_get_tag = 2'b01;
      dir_get_dat = {32'h0, 32'h1};
      @(posedge gclk);
      #1;
      dir_get_vld = 2'b00;
      xact(0, 0, 0, 32'h0, 1, 10, got, cyc);
      chk("tag_mismatch_got", got, 1);
      @(negedge gclk);
      chk("tag_mismatch_err", tag_err_o, 1);
      chk("tag_mismatch_dat", xwb_if.xwb_dat_o, 32'h1);
      @(negedge gclk);
      chk("tag_err_one_cycle", tag_err_o, 0);

      // Held strobe with two entries available: acks one cycle apart.
      @(posedge gclk);
      #1;
      dir_get_vld = 2'b10;
      dir_get_tag = 2'b10;
      dir_get_dat = {32'hA5A50001, 32'h0};
      @(posedge gclk);
      #1;
      dir_get_dat = {32'hA5A50002, 32'h0};
      @(posedge gclk);
      #1;
      dir_get_vld = 2'b00;
      xact(0, 1, 1, 32'h0, 2, 10, got, cyc);
      chk("held_got", got, 2);
      chk("held_cycles", cyc, 3);

      // Randomized traffic on both sides.
      acc_rand = 1'b1;
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge gclk);
            #1;
            xwb_if.xwb_wre_i = 1'($urandom);
            xwb_if.xwb_adr_i = (AEMB_XWB-2)'($urandom);
            xwb_if.xwb_stb_i = 1'($urandom);
            xwb_if.xwb_cyc_i = ~xwb_if.xwb_stb_i;
            repeat (2) @(posedge gclk);
            #1;
            xwb_if.xwb_stb_i = 1'b0;
            xwb_if.xwb_cyc_i = 1'b0;
         end else begin
            xact(1'($urandom), $urandom_range(0, CH-1), 1'($urandom), $urandom,
                 $urandom_range(1, 2), 40, got, cyc);
         end
      end
      acc_rand    = 1'b0;
      dir_put_rdy = 2'b00;
      dir_get_vld = 2'b00;
      repeat (2) @(posedge gclk);
      rst_assert();
      rst_release();

      // Reset while a GET is blocked and ch1 PUT holds three entries.
      for (int i = 0; i < 3; i++) begin
         xact(1, 1, 0, 32'h200 + i, 1, 10, got, cyc);
         chk($sformatf("pre_rst_put%0d", i), got, 1);
      end
      @(posedge gclk);
      #1;
      xwb_if.xwb_wre_i = 1'b0;
      xwb_if.xwb_adr_i = '0;
      xwb_if.xwb_stb_i = 1'b1;
      xwb_if.xwb_cyc_i = 1'b1;
      repeat (3) @(posedge gclk);
      rst_assert();
      rst_release();
      acks = 0;
      repeat (6) begin
         @(posedge gclk);
         #1;
         if (xwb_if.xwb_ack_o) acks++;
      end
      chk("aborted_no_ack", acks, 0);
      chk("post_rst_put_vld", put_vld_o, 0);
      chk("post_rst_get_rdy", get_rdy_o, {CH{1'b1}});
      xwb_if.xwb_stb_i = 1'b0;
      xwb_if.xwb_cyc_i = 1'b0;
      repeat (2) @(posedge gclk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
